fifo_rd_streamer: RTL and testbench
===================================

# fifo_rd_streamer

Read-side engine for the team's synchronous FIFO. It pops words through the FIFO's `r_en`/`empty`/`data_out` port and presents them downstream as a valid/ready stream. Its 2-entry output buffer sustains one word per cycle under continuous `m_ready`. It sits between a FIFO instance and any stream consumer, and counts delivered words for debug and scoreboarding.

## Interface
- `DATA_WIDTH`, 8, FIFO and stream word width
- `COUNT_WIDTH`, 16, width of the delivered-word counter

- `clk` in 1: single clock, all logic on the rising edge
- `rst` in 1: reset, asynchronous, active-high
- `enable` in 1: permits new FIFO reads while high
- `fifo_empty` in 1: FIFO `empty` flag
- `fifo_r_en` out 1: FIFO read strobe
- `fifo_rdata` in DATA_WIDTH: FIFO `data_out`, valid the cycle after `fifo_r_en` is sampled high
- `m_valid` out 1: stream word valid
- `m_ready` in 1: stream consumer ready
- `m_data` out DATA_WIDTH: stream word
- `word_count` out COUNT_WIDTH: stream handshakes completed since reset

## Operation
- Registered state:
  - `occ` (0..2): buffered words, in states EMPTY/ONE/TWO.
  - `inflight` (0/1): a read was issued last cycle and its data is arriving now.
- `pop` = `m_valid & m_ready`.
- `fifo_r_en` = `enable & !fifo_empty & (occ + inflight - pop < 2)`. This is combinational from registered state, `fifo_empty`, `enable` and `m_ready`, and is forced to 0 while `rst` is high.
- `inflight` next = `fifo_r_en`.
- When `inflight` = 1, `fifo_rdata` is written into the buffer tail unconditionally. Credit accounting guarantees space, so overflow is impossible.
- `occ` next = `occ + inflight - pop`.
  - EMPTY→ONE on arrival without pop.
  - ONE→TWO on arrival without pop.
  - TWO→ONE on pop without arrival.
  - ONE→EMPTY on pop without arrival.
  - Arrival and pop in the same cycle holds the state.
- Output behaviour:
  - `m_valid` = (`occ` != 0).
  - `m_data` = buffer head.
  - Order is strictly FIFO.
- `word_count` increments by 1 on each `pop` and wraps modulo 2^COUNT_WIDTH.
- `enable` low blocks new reads only. In-flight data is still captured and the buffer still drains.
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `fifo_r_en` = 0, `word_count` = 0.
  - `occ` = EMPTY, `inflight` = 0, buffer contents = 0.
- Reset mid-operation clears all state immediately. The FIFO is reset by the same event at system level, so a lost in-flight word is acceptable.

## Timing
- Latency:
  - Cycle N: `fifo_empty` low and `occ` = EMPTY → `fifo_r_en` high.
  - Cycle N+1: data on `fifo_rdata`.
  - Cycle N+2: `m_valid` high with that data.
  - First-word latency is 2 cycles.
- Throughput: with `m_ready` held high and the FIFO non-empty, the block reaches steady state `occ`=ONE, `inflight`=1 and issues a read and a handshake every cycle.
- Backpressure:
  - While `m_valid & !m_ready`, `m_data` and `m_valid` hold stable. A word is never dropped or reordered.
  - With `m_ready` low, at most 2 words are pulled from the FIFO. `fifo_r_en` stays low once `occ + inflight` = 2.
- FIFO empty: `fifo_r_en` is never asserted while `fifo_empty` is high.
- `fifo_empty` rising in the same cycle as an issued read is safe. The FIFO's own empty gating governs that read, and this block never reads on empty.
- Simultaneous arrival and pop at TWO cannot occur: credit prevents arrival when `occ + inflight` would exceed 2.

## Structure
- Shared package `fifo_stream_pkg`:
  - `DATA_WIDTH` and `COUNT_WIDTH` defaults.
  - Occupancy state encoding (EMPTY=0, ONE=1, TWO=2).
  - Word typedef.
- Sub-module `stream_skid_buf`: 2-entry register buffer with head/tail select, push, pop and occupancy. The credit logic, read strobe and counter stay in the top module.

## Test plan
- Reset then steady flow:
  - Stimulus: reset the FIFO and this block; load the FIFO with 0x11,0x22,0x33; hold `m_ready`=1.
  - Response: `m_valid` first rises 2 cycles after the first `fifo_r_en`; words are delivered on consecutive cycles in order; `word_count`=3; `fifo_r_en` is never high while `fifo_empty`=1.
- Backpressure:
  - Stimulus: load 5 words and hold `m_ready`=0 for 10 cycles.
  - Response: exactly 2 `fifo_r_en` pulses; `m_data` holds word 0 stable; after `m_ready` rises, all 5 words arrive in order with no gaps beyond 1 cycle.
- Alternating ready:
  - Stimulus: 30 random words with `m_ready` toggling every cycle.
  - Response: the scoreboard queue matches every handshake; `word_count`=30.
- Enable gating:
  - Stimulus: deassert `enable` while `occ`=ONE and `inflight`=1.
  - Response: no further `fifo_r_en`; the 2 buffered words drain; `m_valid` then drops.
- Reset mid-stream:
  - Stimulus: assert `rst` asynchronously between edges while `occ`=TWO.
  - Response: `m_valid`, `fifo_r_en` and `word_count` go to 0 immediately, without waiting for a clock edge.
- Counter wrap:
  - Stimulus: `COUNT_WIDTH`=4, 17 handshakes.
  - Response: `word_count`=1.

Source files
------------

// File: rtl/fifo_stream_pkg.sv
// Shared types and defaults for the FIFO read-side streamer.
// The occupancy encoding is shared by the top module and the skid buffer.
package fifo_stream_pkg;

  localparam int unsigned DefaultDataWidth  = 8;
  localparam int unsigned DefaultCountWidth = 16;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

  typedef logic [DefaultDataWidth-1:0] word_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register buffer with a head pointer and an occupancy state.
// Push writes the tail and pop advances the head; the caller guarantees no overflow.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned Width = DefaultDataWidth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output occ_e             occ_o,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] buf_q [2];
  logic [Width-1:0] buf_d [2];
  logic             head_q, head_d;
  logic             tail_idx;
  occ_e             occ_q, occ_d;

  // Tail sits one past the head when a word is already held.
  assign tail_idx = head_q ^ (occ_q == OccOne);

  always_comb begin
    buf_d  = buf_q;
    head_d = head_q;
    occ_d  = occ_q;
    if (push_i) buf_d[tail_idx] = data_i;
    if (pop_i)  head_d = ~head_q;
    unique case (occ_q)
      OccEmpty: if (push_i) occ_d = OccOne;
      OccOne: begin
        if (push_i && !pop_i)      occ_d = OccTwo;
        else if (!push_i && pop_i) occ_d = OccEmpty;
      end
      OccTwo:   if (pop_i && !push_i) occ_d = OccOne;
      default:  occ_d = OccEmpty;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      occ_q    <= OccEmpty;
    end else begin
      buf_q  <= buf_d;
      head_q <= head_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign data_o = buf_q[head_q];

endmodule

// File: rtl/fifo_rd_streamer.sv
// Pops words from a synchronous FIFO and presents them as a valid/ready stream.
// Credit logic keeps buffered plus in-flight words at or below two.
module fifo_rd_streamer
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
  parameter int unsigned COUNT_WIDTH = DefaultCountWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   fifo_empty_i,
  output logic                   fifo_r_en_o,
  input  logic [DATA_WIDTH-1:0]  fifo_rdata_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DATA_WIDTH-1:0]  m_data_o,
  output logic [COUNT_WIDTH-1:0] word_count_o
);

  occ_e                   occ;
  logic                   inflight_q, inflight_d;
  logic                   pop;
  logic [2:0]             credit;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign m_valid_o = (occ != OccEmpty);
  assign pop       = m_valid_o & m_ready_i;

  // Words that will be held after this edge if no new read is issued.
  assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    fifo_r_en_o = ~rst_i & enable_i & ~fifo_empty_i & (credit < 3'd2);
    inflight_d  = fifo_r_en_o;
    count_d     = count_q;
    if (pop) count_d = count_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
    end
  end

  stream_skid_buf #(
    .Width (DATA_WIDTH)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (inflight_q),
    .pop_i  (pop),
    .data_i (fifo_rdata_i),
    .occ_o  (occ),
    .data_o (m_data_o)
  );

  assign word_count_o = count_q;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Directed bench for fifo_rd_streamer with a behavioural FIFO and a scoreboard queue.
// A second instance with a 4-bit counter shares the stimulus for the wrap check.
module tb_fifo_rd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        m_ready = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata = '0;
  logic        fifo_r_en;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [15:0] word_count;
  logic        w4_r_en;
  logic        w4_valid;
  logic [7:0]  w4_data;
  logic [3:0]  w4_count;

  logic [7:0] fifo_mem [1024];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic [7:0] exp_q [$];

  int checks = 0, failures = 0;
  int cyc, hs_cnt, ren_cnt, empty_viol, first_ren, first_valid, last_hs, max_gap;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .fifo_empty_i (fifo_empty),
    .fifo_r_en_o  (fifo_r_en),
    .fifo_rdata_i (fifo_rdata),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .word_count_o (word_count)
  );

  fifo_rd_streamer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .fifo_empty_i (fifo_empty),
    .fifo_r_en_o  (w4_r_en),
    .fifo_rdata_i (fifo_rdata),
    .m_valid_o    (w4_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (w4_data),
    .word_count_o (w4_count)
  );

  // Behavioural FIFO: data appears the cycle after the read strobe is sampled.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_r_en && (rd_ptr != wr_ptr)) begin
      fifo_rdata <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [7:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic clr_stats();
    cyc = 0; hs_cnt = 0; ren_cnt = 0; empty_viol = 0;
    first_ren = -1; first_valid = -1; last_hs = -1; max_gap = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    wr_ptr = rd_ptr;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_stats();
  endtask

  // Samples the values that the next rising edge will see, then advances one cycle.
  task automatic step();
    logic [7:0] expv;
    #1;
    if (fifo_r_en) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc;
      if (fifo_empty) empty_viol++;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL hs_data: got unexpected word %h, required no handshake", m_data);
      end else begin
        expv = exp_q.pop_front();
        if (m_data !== expv) begin
          failures++;
          $display("FAIL hs_data: got %h required %h", m_data, expv);
        end
      end
      if (last_hs >= 0 && (cyc - last_hs) > max_gap) max_gap = cyc - last_hs;
      last_hs = cyc;
      hs_cnt++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    enable = 1'b1;
    m_ready = 1'b0;
    rst = 1'b1;
    wr_ptr = rd_ptr;
    exp_q.delete();
    load(8'hA5);
    repeat (2) @(negedge clk);
    checks++; if (fifo_r_en !== 1'b0) begin failures++; $display("FAIL rst_r_en: got %b required 0", fifo_r_en); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b required 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h required 00", m_data); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL rst_count: got %0d required 0", word_count); end
    checks++; if (w4_count !== 4'd0) begin failures++; $display("FAIL rst_count4: got %0d required 0", w4_count); end
    wr_ptr = rd_ptr;
    exp_q.delete();
    rst = 1'b0;
    clr_stats();
  endtask

  task automatic test_steady();
    do_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33);
    repeat (10) step();
    checks++; if (first_ren !== 0) begin failures++; $display("FAIL steady_first_ren: got cycle %0d required 0", first_ren); end
    checks++; if (first_valid - first_ren !== 2) begin failures++; $display("FAIL steady_latency: got %0d required 2", first_valid - first_ren); end
    checks++; if (hs_cnt !== 3 || max_gap !== 1) begin failures++; $display("FAIL steady_flow: got hs=%0d gap=%0d required hs=3 gap=1", hs_cnt, max_gap); end
    checks++; if (word_count !== 16'd3) begin failures++; $display("FAIL steady_count: got %0d required 3", word_count); end
    checks++; if (ren_cnt !== 3) begin failures++; $display("FAIL steady_reads: got %0d required 3", ren_cnt); end
    checks++; if (empty_viol !== 0) begin failures++; $display("FAIL steady_empty_read: got %0d required 0", empty_viol); end
  endtask

  task automatic test_backpressure();
    int unstable = 0;
    do_reset();
    enable = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(8'h50 + 8'(i));
    repeat (10) begin
      step();
      if (m_valid && m_data !== 8'h50) unstable++;
    end
    checks++; if (ren_cnt !== 2) begin failures++; $display("FAIL bp_reads: got %0d required 2", ren_cnt); end
    checks++; if (m_valid !== 1'b1 || unstable !== 0) begin failures++; $display("FAIL bp_hold: got valid=%b unstable=%0d required valid=1 unstable=0", m_valid, unstable); end
    m_ready = 1'b1;
    repeat (12) step();
    checks++; if (hs_cnt !== 5) begin failures++; $display("FAIL bp_drain: got %0d required 5", hs_cnt); end
    checks++; if (max_gap !== 1) begin failures++; $display("FAIL bp_gap: got %0d required 1", max_gap); end
    checks++; if (word_count !== 16'd5) begin failures++; $display("FAIL bp_count: got %0d required 5", word_count); end
  endtask

  task automatic test_alternating();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) load(8'($urandom_range(0, 255)));
    m_ready = 1'b0;
    for (int i = 0; i < 300 && hs_cnt < 30; i++) begin
      m_ready = ~m_ready;
      step();
    end
    checks++; if (hs_cnt !== 30) begin failures++; $display("FAIL alt_hs: got %0d required 30", hs_cnt); end
    checks++; if (word_count !== 16'd30) begin failures++; $display("FAIL alt_count: got %0d required 30", word_count); end
    checks++; if (w4_count !== 4'd14) begin failures++; $display("FAIL alt_count4: got %0d required 14", w4_count); end
    checks++; if (empty_viol !== 0) begin failures++; $display("FAIL alt_empty_read: got %0d required 0", empty_viol); end
  endtask

  task automatic test_enable_gating();
    do_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) load(8'h60 + 8'(i));
    step(); step();
    checks++; if (m_valid !== 1'b1 || ren_cnt !== 2) begin failures++; $display("FAIL en_setup: got valid=%b reads=%0d required valid=1 reads=2", m_valid, ren_cnt); end
    enable = 1'b0;
    ren_cnt = 0;
    hs_cnt = 0;
    repeat (6) step();
    checks++; if (ren_cnt !== 0) begin failures++; $display("FAIL en_reads: got %0d required 0", ren_cnt); end
    checks++; if (hs_cnt !== 2) begin failures++; $display("FAIL en_drain: got %0d required 2", hs_cnt); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL en_valid: got %b required 0", m_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    load(8'h77);
    repeat (4) step();
    m_ready = 1'b0;
    load(8'h81); load(8'h82); load(8'h83);
    repeat (4) step();
    checks++; if (word_count !== 16'd1 || m_valid !== 1'b1) begin failures++; $display("FAIL mid_pre: got count=%0d valid=%b required count=1 valid=1", word_count, m_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b required 0", m_valid); end
    checks++; if (fifo_r_en !== 1'b0) begin failures++; $display("FAIL mid_r_en: got %b required 0", fifo_r_en); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL mid_count: got %0d required 0", word_count); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL mid_data: got %h required 00", m_data); end
    wr_ptr = rd_ptr;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    clr_stats();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) load(8'hC0 + 8'(i));
    repeat (25) step();
    checks++; if (hs_cnt !== 17) begin failures++; $display("FAIL wrap_hs: got %0d required 17", hs_cnt); end
    checks++; if (w4_count !== 4'd1) begin failures++; $display("FAIL wrap_count4: got %0d required 1", w4_count); end
    checks++; if (word_count !== 16'd17) begin failures++; $display("FAIL wrap_count16: got %0d required 17", word_count); end
  endtask

  initial begin
    clr_stats();
    test_reset();
    test_steady();
    test_backpressure();
    test_alternating();
    test_enable_gating();
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
